// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Byte handshake between the upstream command logic and the UART transmit
//   serializer.
//   iData   byte to send; sampled only on handshake
//   iValid  iData valid
//   oReady  serializer is idle and can take a byte
//   master: upstream producer; slave: serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] iData;
    logic                 iValid;
    logic                 oReady;

    modport master (output iData, output iValid, input oReady);
    modport slave  (input iData, input iValid, output oReady);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit serializer driven by an external baud tick. One byte is
//   accepted per valid/ready handshake and sent as a start bit, LSB-first
//   data, an optional parity bit and one or two stop bits. Each bit lasts one
//   tick interval.
// Ports
//   iClk        system clock
//   iRst        asynchronous active-low reset
//   iBaud_tick  one-cycle pulse per bit period
//   bus         slave side of the byte handshake (iData, iValid, oReady)
//   oTx         registered serial line, idle high
//   oBusy       high from the cycle after the handshake until frame complete
//   oDone       one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,  // 5..8
    parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1   // 1 or 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iBaud_tick,
    uart_tx_serializer_if.slave  bus,
    output logic                 oTx,
    output logic                 oBusy,
    output logic                 oDone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // oReady is constantly high here, so iValid alone is the handshake.
                if (bus.iValid) begin
                    shift_d = bus.iData;
                    // Parity is taken from the latched byte, before any shifting.
                    par_d   = (PARITY == 2) ? ^bus.iData : ~^bus.iData;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // Waiting for a tick here keeps the start bit a full period long.
                bit_cnt_d  = '0;
                stop_cnt_d = '0;
                if (iBaud_tick) state_d = S_START;
            end
            S_START: begin
                if (iBaud_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (iBaud_tick) begin
                    shift_d = shift_q >> 1;
                    // Counter holds at the last bit rather than wrapping.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (iBaud_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (iBaud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The line is decoded from the next state so that oTx, although
    // registered, changes in the same cycle as the state register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.oReady = (state_q == S_IDLE);
    assign oTx        = tx_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Four serializers (8N1, 8E1, 8O1, 8N2) share one stimulus stream. A
//   frame-list model per instance predicts every output on every cycle, and
//   directed checks pin decoded bytes, parity bits and frame timing.
module tb_uart_tx_serializer;

    localparam int PAR [4] = '{0, 2, 1, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    bit         tick_mode = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    wire [3:0] tx_v, rdy_v, busy_v, done_v;

    uart_tx_serializer_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus3 ();

    assign bus0.iData = data; assign bus0.iValid = valid;
    assign bus1.iData = data; assign bus1.iValid = valid;
    assign bus2.iData = data; assign bus2.iValid = valid;
    assign bus3.iData = data; assign bus3.iValid = valid;
    assign rdy_v = {bus3.oReady, bus2.oReady, bus1.oReady, bus0.oReady};

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .bus(bus0),
        .oTx(tx_v[0]), .oBusy(busy_v[0]), .oDone(done_v[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .bus(bus1),
        .oTx(tx_v[1]), .oBusy(busy_v[1]), .oDone(done_v[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .bus(bus2),
        .oTx(tx_v[2]), .oBusy(busy_v[2]), .oDone(done_v[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .bus(bus3),
        .oTx(tx_v[3]), .oBusy(busy_v[3]), .oDone(done_v[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: every 16 cycles, or every cycle in consecutive mode.
    initial begin
        int tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            tick = tick_mode ? 1'b1 : ((tcnt % 16) == 0);
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h",
                         name, k, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Index 0 is the wait-for-tick slot (line high), 1 the start bit, then
    // data, optional parity and stop bits; the line shows the entry at m_idx.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] v = '1;
        v[1] = 1'b0;
        for (int i = 0; i < 8; i++) v[2+i] = d[i];
        if (par == 2) v[10] = ^d;
        else if (par == 1) v[10] = ~^d;
        return v;
    endfunction

    function automatic int last_idx(input int k);
        return 9 + ((PAR[k] != 0) ? 1 : 0) + SB[k];
    endfunction

    logic        m_busy [4];
    logic        m_done [4];
    int          m_idx  [4];
    logic [15:0] m_bits [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_idx[k]  <= 0;
                m_bits[k] <= '1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_done[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (valid) begin
                        m_busy[k] <= 1'b1;
                        m_idx[k]  <= 0;
                        m_bits[k] <= frame_bits(data, PAR[k]);
                    end
                end else if (tick) begin
                    if (m_idx[k] == last_idx(k)) begin
                        m_busy[k] <= 1'b0;
                        m_done[k] <= 1'b1;
                    end else begin
                        m_idx[k] <= m_idx[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("tx",    k, 32'(tx_v[k]),   32'(m_busy[k] ? m_bits[k][m_idx[k]] : 1'b1));
            chk("ready", k, 32'(rdy_v[k]),  32'(!m_busy[k]));
            chk("busy",  k, 32'(busy_v[k]), 32'(m_busy[k]));
            chk("done",  k, 32'(done_v[k]), 32'(m_done[k]));
        end
    end

    // ---------------- directed helpers ----------------
    logic [3:0] samp [12];
    int         dly [4];
    int         ndone [4];
    logic [3:0] rdy_at_done;
    int         t_fall;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy_v !== 4'h0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", 0, 32'(w < 1000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Waits for instance 0's start bit, then samples all lines mid-bit.
    task automatic capture(input int per, input int ncyc);
        int w = 0;
        @(negedge clk);
        while (tx_v[0] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("start_timeout", 0, 32'(w < 200), 32'd1);
        t_fall = cyc;
        rdy_at_done = '0;
        for (int k = 0; k < 4; k++) begin
            dly[k] = -1;
            ndone[k] = 0;
        end
        for (int b = 0; b < 12; b++) samp[b] = 'x;
        for (int c = 0; c < ncyc; c++) begin
            for (int b = 0; b < 12; b++)
                if (c == per / 2 + per * b) samp[b] = tx_v;
            for (int k = 0; k < 4; k++)
                if (done_v[k]) begin
                    ndone[k]++;
                    if (dly[k] < 0) begin
                        dly[k] = c;
                        rdy_at_done[k] = rdy_v[k];
                    end
                end
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] dec(input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = samp[i+1][k];
        return v;
    endfunction

    function automatic logic [9:0] line10(input int k);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = samp[i][k];
        return v;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int t1;
        int w;

        // Reset with iValid high.
        valid = 1'b1;
        data  = 8'hA5;
        repeat (5) @(negedge clk);
        chk("rst_tx",    0, 32'(tx_v),   32'hF);
        chk("rst_ready", 0, 32'(rdy_v),  32'hF);
        chk("rst_busy",  0, 32'(busy_v), 32'h0);
        chk("rst_done",  0, 32'(done_v), 32'h0);
        valid = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
        send(8'hA5);
        capture(16, 180);
        chk("a5_line",    0, 32'(line10(0)), 32'b1101001010);
        chk("a5_ndone",   0, 32'(ndone[0]), 32'd1);
        chk("a5_rdydone", 0, 32'(rdy_at_done[0]), 32'd1);
        chk("a5_len_n1",  0, 32'(dly[0]), 32'd160);
        chk("a5_len_n2",  3, 32'(dly[3]), 32'd176);
        wait_idle();

        // Parity on 0x07: even -> 1, odd -> 0; 11-bit frames.
        send(8'h07);
        capture(16, 180);
        chk("par_even", 1, 32'(samp[9][1]), 32'd1);
        chk("par_odd",  2, 32'(samp[9][2]), 32'd0);
        chk("par_none_stop", 0, 32'(samp[9][0]), 32'd1);
        chk("len_even", 1, 32'(dly[1]), 32'd176);
        chk("len_odd",  2, 32'(dly[2]), 32'd176);
        chk("dec_07",   1, 32'(dec(1)), 32'h07);
        wait_idle();

        // Back-to-back: iValid held, next byte presented in the oDone cycle.
        @(negedge clk);
        data  = 8'h55;
        valid = 1'b1;
        fork
            capture(16, 170);
            begin
                w = 0;
                @(negedge clk);
                while (done_v[0] !== 1'b1 && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                chk("b2b_done_timeout", 0, 32'(w < 400), 32'd1);
                data = 8'h0F;
                @(posedge clk);
                #1;
                valid = 1'b0;
            end
        join
        chk("b2b_first",     0, 32'(dec(0)), 32'h55);
        chk("b2b_first_stp", 0, 32'(samp[9][0]), 32'd1);
        t1 = t_fall + dly[0];
        capture(16, 170);
        chk("b2b_second", 0, 32'(dec(0)), 32'h0F);
        chk("b2b_gap_ok", 0, 32'((t_fall - t1) >= 1 && (t_fall - t1) <= 17), 32'd1);
        wait_idle();

        // Reset during data bit 3 of 0x00, then a clean 0x3C frame.
        send(8'h00);
        w = 0;
        @(negedge clk);
        while (tx_v[0] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("abort_start", 0, 32'(w < 200), 32'd1);
        repeat (72) @(negedge clk);
        chk("abort_pre", 0, 32'(tx_v[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_tx",   0, 32'(tx_v),   32'hF);
        chk("abort_busy", 0, 32'(busy_v), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h3C);
        capture(16, 180);
        chk("post_abort",       0, 32'(dec(0)), 32'h3C);
        chk("post_abort_start", 0, 32'(samp[0][0]), 32'd0);
        chk("post_abort_ndone", 0, 32'(ndone[0]), 32'd1);
        wait_idle();

        // Input isolation and two stop bits.
        send(8'hA5);
        fork
            capture(16, 180);
            begin
                repeat (40) @(negedge clk);
                data  = 8'h3C;
                valid = 1'b1;
                @(posedge clk);
                #1;
                valid = 1'b0;
                repeat (30) @(negedge clk);
                data = 8'hFF;
            end
        join
        chk("iso_n1",    0, 32'(dec(0)), 32'hA5);
        chk("iso_n2",    3, 32'(dec(3)), 32'hA5);
        chk("iso_ndone", 0, 32'(ndone[0]), 32'd1);
        chk("stop2_a",   3, 32'(samp[9][3]), 32'd1);
        chk("stop2_b",   3, 32'(samp[10][3]), 32'd1);
        chk("stop2_len", 3, 32'(dly[3]), 32'd176);
        repeat (50) @(negedge clk);
        chk("no_extra_frame", 0, 32'(busy_v), 32'h0);
        wait_idle();

        // Ticks on consecutive cycles: one cycle per bit.
        tick_mode = 1'b1;
        send(8'hA5);
        capture(1, 30);
        chk("fast_line",   0, 32'(line10(0)), 32'b1101001010);
        chk("fast_len_n1", 0, 32'(dly[0]), 32'd10);
        chk("fast_len_n2", 3, 32'(dly[3]), 32'd11);
        tick_mode = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
